// File: rtl/password_candidate_gen_if.sv
// Handshake/config bundle between the search controller, the generator and the hash pipeline.
interface password_candidate_gen_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                 start;
  logic                 abort;
  logic                 enable;
  logic [7:0]           start_char;
  logic [2:0]           stride;
  logic                 ready;
  logic                 valid;
  logic [8*MAX_LEN-1:0] password;
  logic [LW-1:0]        num_chars;
  logic                 busy;
  logic                 done;
  logic [63:0]          cand_count;

  modport master (
    output start, abort, enable, start_char, stride, ready,
    input  valid, password, num_chars, busy, done, cand_count
  );

  modport slave (
    input  start, abort, enable, start_char, stride, ready,
    output valid, password, num_chars, busy, done, cand_count
  );
endinterface

// File: rtl/password_candidate_gen.sv
// Synchronous brute-force candidate generator: strided odometer, shortest length first, lane-split.
// Optional accepted-candidate counter enabled by defining PWGEN_CAND_COUNT_EN.
module password_candidate_gen #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] CHAR_HI   = 8'h7E,
  parameter int         NUM_LANES = 1,
  parameter int         LANE      = 0
) (
  input logic                     i_clock,
  input logic                     i_reset,
  password_candidate_gen_if.slave bus
);
  localparam int         LW    = $clog2(MAX_LEN + 1);
  localparam logic [8:0] HI9   = {1'b0, CHAR_HI};
  localparam logic [8:0] LANE9 = 9'(LANE);
  localparam logic [8:0] NL9   = 9'(NUM_LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  logic [MAX_LEN-1:0][7:0] r_chars;
  logic [LW-1:0]           r_len;
  logic [8:0]              r_base0, r_step0, r_base, r_step;
  logic                    r_valid, r_busy, r_done;

  logic [8:0]              w_s9, w_base0_new, w_step0_new;
  logic                    w_fire, w_len_max, w_empty;
  logic [MAX_LEN-1:0][7:0] w_next;
  logic [MAX_LEN:0]        w_carry;
  logic                    w_wrap;

  assign w_s9        = (bus.stride == 3'd0) ? 9'd1 : {6'd0, bus.stride};
  assign w_base0_new = {1'b0, bus.start_char} + LANE9 * w_s9;
  assign w_step0_new = NL9 * w_s9;
  assign w_empty     = (w_base0_new > HI9) || (bus.start_char > CHAR_HI);
  assign w_fire      = r_valid && bus.ready && bus.enable;
  assign w_len_max   = (r_len == LW'(MAX_LEN));

  // Odometer: char 0 is least significant. On a full wrap every active char has
  // already fallen back to its base, so growing only needs the new top char seeded.
  always_comb begin
    logic [8:0] w_b, w_st, w_sum;
    w_next     = r_chars;
    w_carry    = '0;
    w_carry[0] = 1'b1;
    w_wrap     = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_b   = (i == 0) ? r_base0 : r_base;
      w_st  = (i == 0) ? r_step0 : r_step;
      w_sum = {1'b0, r_chars[i]} + w_st;
      if (w_carry[i] && (i < int'(r_len))) begin
        if (w_sum > HI9) begin
          w_next[i]    = w_b[7:0];
          w_carry[i+1] = 1'b1;
        end else begin
          w_next[i]    = w_sum[7:0];
        end
      end
      if (i == int'(r_len) - 1) w_wrap = w_carry[i+1];
      if (i == int'(r_len) && w_wrap) w_next[i] = r_base[7:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || bus.abort) begin
      r_state <= S_IDLE;
      r_chars <= '0;
      r_len   <= '0;
      r_base0 <= '0;
      r_step0 <= '0;
      r_base  <= '0;
      r_step  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_base0 <= w_base0_new;
            r_step0 <= w_step0_new;
            r_base  <= {1'b0, bus.start_char};
            r_step  <= w_s9;
            r_chars <= '0;
            if (w_empty) begin
              r_state <= S_DONE;
              r_len   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_chars[0] <= w_base0_new[7:0];
              r_len      <= LW'(1);
              r_valid    <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (w_wrap && w_len_max) begin
              r_state <= S_DONE;
              r_chars <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_chars <= w_next;
              if (w_wrap) r_len <= r_len + LW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PWGEN_CAND_COUNT_EN
  logic [63:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || bus.abort)                  r_cnt <= '0;
    else if (bus.start && (r_state != S_RUN))  r_cnt <= '0;
    else if (w_fire && !(&r_cnt))              r_cnt <= r_cnt + 64'd1;
  end

  assign bus.cand_count = r_cnt;
`else
  assign bus.cand_count = '0;
`endif

  assign bus.valid     = r_valid;
  assign bus.password  = r_chars;
  assign bus.num_chars = r_len;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_password_candidate_gen.sv
// Random and directed checks of password_candidate_gen against an enumerating reference model.
module tb_password_candidate_gen;
  localparam int         ML = 2;
  localparam logic [7:0] HI = 8'h7A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  password_candidate_gen_if #(.MAX_LEN(ML)) if0 ();
  password_candidate_gen_if #(.MAX_LEN(ML)) ifa ();
  password_candidate_gen_if #(.MAX_LEN(ML)) ifb ();

  password_candidate_gen #(.MAX_LEN(ML), .CHAR_HI(HI), .NUM_LANES(1), .LANE(0))
    u0 (.i_clock(clk), .i_reset(rst), .bus(if0));
  password_candidate_gen #(.MAX_LEN(ML), .CHAR_HI(HI), .NUM_LANES(2), .LANE(0))
    ua (.i_clock(clk), .i_reset(rst), .bus(ifa));
  password_candidate_gen #(.MAX_LEN(ML), .CHAR_HI(HI), .NUM_LANES(2), .LANE(1))
    ub (.i_clock(clk), .i_reset(rst), .bus(ifb));

  typedef struct { int len; int pw; } cand_t;
  cand_t mq[$];
  cand_t qa[$];
  cand_t qb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
`ifdef PWGEN_CAND_COUNT_EN
    return 64'(n);
`else
    return 64'(n) & 64'd0;
`endif
  endfunction

  // Enumerate candidates from the alphabet: first char restricted to this lane's
  // share of alphabet indices, char 0 varying fastest.
  task automatic build(input int sc, input int st, input int nl, input int ln);
    int s;
    int al[$];
    int f[$];
    mq.delete();
    s = (st == 0) ? 1 : st;
    if (sc > int'(HI)) return;
    for (int c = sc; c <= int'(HI); c += s) al.push_back(c);
    for (int k = 0; k < al.size(); k++) if (k % nl == ln) f.push_back(al[k]);
    foreach (f[i]) mq.push_back('{1, f[i]});
    foreach (al[j]) foreach (f[i]) mq.push_back('{2, al[j] * 256 + f[i]});
  endtask

  task automatic idle_in(input int which);
    if (which == 0) begin
      if0.start = 0; if0.abort = 0; if0.enable = 1; if0.ready = 0;
      if0.start_char = 8'h61; if0.stride = 3'd1;
    end else begin
      ifa.start = 0; ifa.abort = 0; ifa.enable = 1; ifa.ready = 0;
      ifa.start_char = 8'h61; ifa.stride = 3'd1;
      ifb.start = 0; ifb.abort = 0; ifb.enable = 1; ifb.ready = 0;
      ifb.start_char = 8'h61; ifb.stride = 3'd1;
    end
  endtask

  task automatic run0(input int sc, input int st, input int rdy_pct, input int en_pct);
    int idx;
    int cyc;
    logic rdy;
    logic en;
    build(sc, st, 1, 0);
    @(negedge clk);
    if0.start_char = 8'(sc); if0.stride = 3'(st); if0.start = 1; if0.ready = 0;
    @(negedge clk);
    if0.start = 0;
    if (mq.size() == 0) chk("empty_valid", if0.valid, 0);
    idx = 0;
    cyc = 0;
    while (idx < mq.size() && cyc < 20000) begin
      chk("valid_held", if0.valid, 1);
      chk("pw", if0.password, mq[idx].pw);
      chk("num_chars", if0.num_chars, mq[idx].len);
      rdy = ($urandom_range(99) < rdy_pct);
      en  = ($urandom_range(99) < en_pct);
      if0.ready = rdy; if0.enable = en;
      if (if0.valid && rdy && en) idx++;
      @(negedge clk);
      cyc++;
    end
    if0.ready = 0; if0.enable = 1;
    chk("transfers", idx, mq.size());
    chk("done", if0.done, 1);
    chk("done_valid", if0.valid, 0);
    chk("done_busy", if0.busy, 0);
    chk("cand_count", if0.cand_count, exp_cnt(mq.size()));
  endtask

  task automatic run_lanes();
    bit seen[int];
    int ia, ib, cyc, dups, total, key;
    build(8'h61, 1, 2, 0); qa = mq;
    build(8'h61, 1, 2, 1); qb = mq;
    build(8'h61, 1, 1, 0); total = mq.size();
    @(negedge clk);
    ifa.start = 1; ifb.start = 1;
    @(negedge clk);
    ifa.start = 0; ifb.start = 0; ifa.ready = 1; ifb.ready = 1;
    ia = 0; ib = 0; cyc = 0; dups = 0;
    while ((ia < qa.size() || ib < qb.size()) && cyc < 5000) begin
      if (ifa.valid) begin
        if (ia < qa.size()) begin
          chk("lane0_pw", ifa.password, qa[ia].pw);
          key = int'(ifa.num_chars) * 65536 + int'(ifa.password);
          if (seen.exists(key)) dups++;
          seen[key] = 1'b1;
        end else chk("lane0_extra", ia, qa.size());
        ia++;
      end
      if (ifb.valid) begin
        if (ib < qb.size()) begin
          chk("lane1_pw", ifb.password, qb[ib].pw);
          key = int'(ifb.num_chars) * 65536 + int'(ifb.password);
          if (seen.exists(key)) dups++;
          seen[key] = 1'b1;
        end else chk("lane1_extra", ib, qb.size());
        ib++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("lane_union", seen.num(), total);
    chk("lane_dups", dups, 0);
    chk("lane0_done", ifa.done, 1);
    chk("lane1_done", ifb.done, 1);
    // Lane 1's first char lands past CHAR_HI, so it has nothing to produce.
    ifa.ready = 0; ifb.ready = 0;
    ifa.start_char = 8'h7A; ifb.start_char = 8'h7A;
    ifa.start = 1; ifb.start = 1;
    @(negedge clk);
    ifa.start = 0; ifb.start = 0;
    chk("lane1_empty_done", ifb.done, 1);
    chk("lane1_empty_valid", ifb.valid, 0);
    chk("lane0_z", ifa.password, 16'h007A);
  endtask

  initial begin
    idle_in(0);
    idle_in(1);
    repeat (2) @(negedge clk);
    chk("rst_valid", if0.valid, 0);
    chk("rst_pw", if0.password, 0);
    chk("rst_num", if0.num_chars, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.done, 0);
    chk("rst_cnt", if0.cand_count, 0);
    rst = 0;
    @(negedge clk);

    run0(8'h61, 1, 100, 100);
    run0(8'h61, 1, 60, 85);
    run0(8'h78, 3, 70, 100);
    run0(8'h70, 0, 80, 90);
    run0(8'h7B, 2, 100, 100);
    for (int r = 0; r < 3; r++)
      run0($urandom_range(8'h58, 8'h7C), $urandom_range(0, 7), $urandom_range(40, 100), 90);

    // Hold under back-pressure and enable=0, start ignored in RUN, abort, reset.
    @(negedge clk);
    if0.start_char = 8'h61; if0.stride = 3'd1; if0.start = 1;
    @(negedge clk);
    if0.start = 0;
    chk("h_a", if0.password, 16'h0061);
    if0.ready = 1;
    @(negedge clk); chk("h_b", if0.password, 16'h0062);
    @(negedge clk); chk("h_c", if0.password, 16'h0063);
    if0.ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", if0.valid, 1);
      chk("hold_pw", if0.password, 16'h0063);
    end
    if0.ready = 1; if0.enable = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_hold_pw", if0.password, 16'h0063);
    end
    if0.enable = 1;
    @(negedge clk);
    chk("after_hold_d", if0.password, 16'h0064);
    if0.ready = 0;
    chk("mid_cnt", if0.cand_count, exp_cnt(3));
    if0.start_char = 8'h70; if0.start = 1;
    @(negedge clk);
    if0.start = 0;
    chk("start_in_run_pw", if0.password, 16'h0064);
    chk("start_in_run_busy", if0.busy, 1);
    if0.abort = 1;
    @(negedge clk);
    if0.abort = 0;
    chk("abort_valid", if0.valid, 0);
    chk("abort_pw", if0.password, 0);
    chk("abort_busy", if0.busy, 0);
    chk("abort_num", if0.num_chars, 0);
    chk("abort_cnt", if0.cand_count, 0);
    if0.start_char = 8'h61; if0.start = 1;
    @(negedge clk);
    if0.start = 0;
    chk("restart_pw", if0.password, 16'h0061);
    chk("restart_valid", if0.valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_valid", if0.valid, 0);
    chk("rst_mid_pw", if0.password, 0);
    chk("rst_mid_busy", if0.busy, 0);
    if0.start = 1; if0.abort = 1;
    @(negedge clk);
    if0.start = 0; if0.abort = 0;
    chk("abort_over_start", if0.busy, 0);
    chk("abort_over_start_v", if0.valid, 0);

    run_lanes();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
